decode_stage: RTL and testbench

Single-cycle instruction-decode stage for the 64-bit LEGv8 datapath, sitting between instruction fetch and execute. It does three things:
- Decodes the 32-bit instruction into an opcode, main control signals and a sign-extended immediate.
- Reads two operands from a 32×64 register file.
- Writes `write_data` back to the destination register at the clock edge that closes the instruction's cycle.

---
 rtl/decode_stage.sv | 106 ++++++++++
 tb/tb_decode_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// LEGv8 single-cycle decode stage: main control decode, immediate generation,
// and a 32x64 register file with combinational reads and edge-triggered writeback.
module decode_stage #(
  parameter int unsigned WORD      = 64,
  parameter int unsigned INSTR_LEN = 32,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic [WORD-1:0]      write_data,
  output logic [10:0]          opcode,
  output logic [WORD-1:0]      sign_extended_output,
  output logic                 reg2_loc,
  output logic                 uncondbranch,
  output logic                 branch,
  output logic                 mem_read,
  output logic                 mem_to_reg,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic [1:0]           alu_op,
  output logic [WORD-1:0]      read_data1,
  output logic [WORD-1:0]      read_data2
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] XZR = IDX_W'(NUM_REGS - 1);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  logic [WORD-1:0]  regs_q [NUM_REGS];
  logic [IDX_W-1:0] rn;
  logic [IDX_W-1:0] rm;
  logic [IDX_W-1:0] rd;

  assign opcode = instruction[31:21];
  assign rn     = instruction[9:5];
  assign rd     = instruction[4:0];
  assign rm     = reg2_loc ? instruction[4:0] : instruction[20:16];

  // Main control and immediate selection; unknown opcodes leave everything zero.
  always_comb begin
    reg2_loc             = 1'b0;
    uncondbranch         = 1'b0;
    branch               = 1'b0;
    mem_read             = 1'b0;
    mem_to_reg           = 1'b0;
    mem_write            = 1'b0;
    alu_src              = 1'b0;
    reg_write            = 1'b0;
    alu_op               = 2'b00;
    sign_extended_output = '0;
    if (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) begin
      reg_write            = 1'b1;
      alu_op               = 2'b10;
      sign_extended_output = {{(WORD-6){1'b0}}, instruction[15:10]};
    end else if (opcode == OP_LDUR) begin
      mem_read             = 1'b1;
      mem_to_reg           = 1'b1;
      alu_src              = 1'b1;
      reg_write            = 1'b1;
      sign_extended_output = {{(WORD-9){instruction[20]}}, instruction[20:12]};
    end else if (opcode == OP_STUR) begin
      reg2_loc             = 1'b1;
      alu_src              = 1'b1;
      mem_write            = 1'b1;
      sign_extended_output = {{(WORD-9){instruction[20]}}, instruction[20:12]};
    end else if (opcode[10:3] == OP_CBZ) begin
      reg2_loc             = 1'b1;
      branch               = 1'b1;
      alu_op               = 2'b01;
      sign_extended_output = {{(WORD-19){instruction[23]}}, instruction[23:5]};
    end else if (opcode[10:5] == OP_B) begin
      uncondbranch         = 1'b1;
      sign_extended_output = {{(WORD-26){instruction[25]}}, instruction[25:0]};
    end
  end

  // X31 reads as zero regardless of array contents.
  assign read_data1 = (rn == XZR) ? '0 : regs_q[rn];
  assign read_data2 = (rm == XZR) ? '0 : regs_q[rm];

  // Reset reloads the preset register image and overrides any pending write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[19] <= WORD'(32);
      regs_q[20] <= WORD'(48);
      regs_q[21] <= WORD'(64);
      regs_q[22] <= WORD'(16);
    end else if (reg_write && (rd != XZR)) begin
      regs_q[rd] <= write_data;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [63:0] write_data;
  logic [10:0] opcode;
  logic [63:0] sign_extended_output;
  logic        reg2_loc, uncondbranch, branch, mem_read, mem_to_reg;
  logic        mem_write, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic [63:0] read_data1, read_data2;
  logic [9:0]  ctrl;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .instruction          (instruction),
    .write_data           (write_data),
    .opcode               (opcode),
    .sign_extended_output (sign_extended_output),
    .reg2_loc             (reg2_loc),
    .uncondbranch         (uncondbranch),
    .branch               (branch),
    .mem_read             (mem_read),
    .mem_to_reg           (mem_to_reg),
    .mem_write            (mem_write),
    .alu_src              (alu_src),
    .reg_write            (reg_write),
    .alu_op               (alu_op),
    .read_data1           (read_data1),
    .read_data2           (read_data2)
  );

  always #5 clk = ~clk;

  // {reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
  assign ctrl = {reg2_loc, uncondbranch, branch, mem_read, mem_to_reg,
                 mem_write, alu_src, reg_write, alu_op};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] add_instr(input logic [4:0] rd, input logic [4:0] rn,
                                            input logic [4:0] rm);
    return {11'b10001011000, rm, 6'd0, rn, rd};
  endfunction

  // Drive an instruction mid-cycle and let the combinational paths settle.
  task automatic drive(input logic [31:0] ins, input logic [63:0] wd);
    instruction = ins;
    write_data  = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset       = 1'b0;
    instruction = 32'd0;
    write_data  = 64'd0;
    tick();
    tick();
    reset = 1'b1;

    // Reset image
    drive(add_instr(5'd31, 5'd19, 5'd20), 64'd0);
    check_eq("rst_x19", read_data1, 64'd32);
    check_eq("rst_x20", read_data2, 64'd48);
    drive(add_instr(5'd31, 5'd21, 5'd22), 64'd0);
    check_eq("rst_x21", read_data1, 64'd64);
    check_eq("rst_x22", read_data2, 64'd16);

    // LDUR X9,[X22,#64]
    drive(32'hF84402C9, 64'd20);
    check_eq("ldur_opcode", 64'(opcode), 64'(11'b11111000010));
    check_eq("ldur_imm", sign_extended_output, 64'h40);
    check_eq("ldur_ctrl", 64'(ctrl), 64'(10'b0001101100));
    check_eq("ldur_rd1", read_data1, 64'd16);
    tick();

    // ADD X10,X19,X9
    drive(32'h8B09026A, 64'd52);
    check_eq("add_ctrl", 64'(ctrl), 64'(10'b0000000110));
    check_eq("add_imm", sign_extended_output, 64'd0);
    check_eq("add_rd1", read_data1, 64'd32);
    check_eq("add_rd2", read_data2, 64'd20);
    tick();

    // Same-cycle read/write of X10 shows the old value until the edge
    drive(add_instr(5'd10, 5'd10, 5'd10), 64'd7);
    check_eq("rw_old", read_data1, 64'd52);
    tick();
    check_eq("rw_new", read_data1, 64'd7);

    // STUR X11,[X22,#96]
    drive(32'hF80602CB, 64'd999);
    check_eq("stur_ctrl", 64'(ctrl), 64'(10'b1000011000));
    check_eq("stur_imm", sign_extended_output, 64'h60);
    check_eq("stur_rd1", read_data1, 64'd16);
    check_eq("stur_rd2", read_data2, 64'd0);
    tick();
    drive(add_instr(5'd31, 5'd11, 5'd9), 64'd0);
    check_eq("stur_nowr_x11", read_data1, 64'd0);
    check_eq("stur_nowr_x9", read_data2, 64'd20);

    // CBZ X11,-5
    drive(32'hB4FFFF6B, 64'd0);
    check_eq("cbz_ctrl", 64'(ctrl), 64'(10'b1010000001));
    check_eq("cbz_imm", sign_extended_output, 64'hFFFFFFFFFFFFFFFB);

    // B 64 and B -55
    drive(32'h14000040, 64'd0);
    check_eq("b_ctrl", 64'(ctrl), 64'(10'b0100000000));
    check_eq("b_imm_pos", sign_extended_output, 64'h40);
    drive(32'h17FFFFC9, 64'd0);
    check_eq("b_imm_neg", sign_extended_output, 64'hFFFFFFFFFFFFFFC9);

    // AND with shamt 42 (zero-extended), and an undefined opcode
    drive({11'b10001010000, 5'd20, 6'd42, 5'd19, 5'd31}, 64'd0);
    check_eq("and_ctrl", 64'(ctrl), 64'(10'b0000000110));
    check_eq("and_shamt", sign_extended_output, 64'd42);
    check_eq("and_rd2", read_data2, 64'd48);
    drive(32'h00000000, 64'd0);
    check_eq("undef_ctrl", 64'(ctrl), 64'd0);
    check_eq("undef_imm", sign_extended_output, 64'd0);

    // ADD X31,X19,X19: write must be ignored
    drive(add_instr(5'd31, 5'd19, 5'd19), 64'd123);
    tick();
    drive(add_instr(5'd31, 5'd31, 5'd19), 64'd0);
    check_eq("xzr_read", read_data1, 64'd0);
    check_eq("xzr_x19", read_data2, 64'd32);

    // Reset during a write to X9 drops the write and restores the image
    drive(32'hF84402C9, 64'd77);
    reset = 1'b0;
    check_eq("rst_ctrl_unaff", 64'(ctrl), 64'(10'b0001101100));
    tick();
    reset = 1'b1;
    drive(add_instr(5'd31, 5'd9, 5'd22), 64'd0);
    check_eq("rst_x9", read_data1, 64'd0);
    check_eq("rst_x22_after", read_data2, 64'd16);
    drive(add_instr(5'd31, 5'd10, 5'd19), 64'd0);
    check_eq("rst_x10", read_data1, 64'd0);
    check_eq("rst_x19_after", read_data2, 64'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
